// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 inverse cipher: one round per clock against an external round-key store.
// Optional feature: define AES_INV_CIPHER_ABORT_EN to add an abort input that cancels a running block.
module aes_inv_cipher_iter #(
   parameter int NR = 10
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [127:0] ciphertext_in,
`ifdef AES_INV_CIPHER_ABORT_EN
   input  logic         abort,
`endif
   output logic         ready,
   output logic         busy,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk_data,
   output logic [127:0] plaintext_out,
   output logic         done
);

   // Inverse S-box, entry 0 in the most significant byte.
   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   typedef enum logic {IDLE, RUN} state_t;

   state_t       state_q, state_d;
   logic [127:0] blk_q, blk_d;
   logic [3:0]   rnd_q, rnd_d;
   logic         done_q, done_d;
   logic [127:0] round_ark, round_mc;

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX_TBL[2047 - 8*int'(x) -: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Multiply by a 4-bit constant; the constant folds away at each call site.
   function automatic logic [7:0] gf_mul_c(input logic [7:0] a, input logic [3:0] c);
      logic [7:0] x2, x4, x8;
      x2 = xtime(a);
      x4 = xtime(x2);
      x8 = xtime(x4);
      return (c[0] ? a : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[3] ? x8 : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[7:0];
      a1 = col[15:8];
      a2 = col[23:16];
      a3 = col[31:24];
      return {gf_mul_c(a0, 4'hb) ^ gf_mul_c(a1, 4'hd) ^ gf_mul_c(a2, 4'h9) ^ gf_mul_c(a3, 4'he),
              gf_mul_c(a0, 4'hd) ^ gf_mul_c(a1, 4'h9) ^ gf_mul_c(a2, 4'he) ^ gf_mul_c(a3, 4'hb),
              gf_mul_c(a0, 4'h9) ^ gf_mul_c(a1, 4'he) ^ gf_mul_c(a2, 4'hb) ^ gf_mul_c(a3, 4'hd),
              gf_mul_c(a0, 4'he) ^ gf_mul_c(a1, 4'hb) ^ gf_mul_c(a2, 4'hd) ^ gf_mul_c(a3, 4'h9)};
   endfunction

   // Row r moves right by r columns: output column c takes input column (c - r) mod 4.
   function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[8*(r + 4*c) +: 8] = inv_sbox(s[8*(r + 4*((c - r + 4) % 4)) +: 8]);
      return o;
   endfunction

   function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         o[32*c +: 32] = inv_mix_column(s[32*c +: 32]);
      return o;
   endfunction

   assign round_ark = inv_shift_sub(blk_q) ^ rk_data;
   assign round_mc  = inv_mix_columns(round_ark);

   always_comb begin
      state_d = state_q;
      blk_d   = blk_q;
      rnd_d   = rnd_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               blk_d   = ciphertext_in ^ rk_data;
               rnd_d   = 4'(NR - 1);
               state_d = RUN;
            end
         end
         RUN: begin
`ifdef AES_INV_CIPHER_ABORT_EN
            if (abort) begin
               blk_d   = '0;
               rnd_d   = '0;
               state_d = IDLE;
            end else
`endif
            if (rnd_q == 4'd0) begin
               blk_d   = round_ark;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               blk_d = round_mc;
               rnd_d = rnd_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         blk_q   <= '0;
         rnd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         blk_q   <= blk_d;
         rnd_q   <= rnd_d;
         done_q  <= done_d;
      end
   end

   assign ready         = (state_q == IDLE);
   assign busy          = ~ready;
   assign rk_idx        = (state_q == RUN) ? rnd_q : 4'(NR);
   assign plaintext_out = blk_q;
   assign done          = done_q;

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 C.1 vectors plus random blocks against a byte-matrix reference model.
module tb_aes_inv_cipher_iter;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [127:0] ciphertext_in;
   logic         ready;
   logic         busy;
   logic [3:0]   rk_idx;
   logic [127:0] rk_data;
   logic [127:0] plaintext_out;
   logic         done;
`ifdef AES_INV_CIPHER_ABORT_EN
   logic         abort;
`endif

   int checks = 0;
   int errors = 0;

   logic [7:0]   sbox  [256];
   logic [7:0]   isbox [256];
   logic [127:0] rk    [11];
   bit           zero_keys = 1'b0;

   logic [127:0] ct_ref, pt_ref;

   always #5 clk = ~clk;

   assign rk_data = zero_keys ? '0 : ((rk_idx <= 4'd10) ? rk[rk_idx] : '0);

   aes_inv_cipher_iter #(.NR(10)) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .ciphertext_in(ciphertext_in),
`ifdef AES_INV_CIPHER_ABORT_EN
      .abort(abort),
`endif
      .ready(ready),
      .busy(busy),
      .rk_idx(rk_idx),
      .rk_data(rk_data),
      .plaintext_out(plaintext_out),
      .done(done)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p ^= x;
         x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
         y = y >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   // FIPS hex strings list byte 0 first; the bus keeps byte 0 in the low bits.
   function automatic logic [127:0] fips(input logic [127:0] h);
      logic [127:0] r;
      for (int i = 0; i < 16; i++) r[8*i +: 8] = h[8*(15 - i) +: 8];
      return r;
   endfunction

   task automatic init_model();
      logic [7:0] inv, b, rcon;
      logic [7:0] w [44][4];
      logic [7:0] t [4];
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         b = inv;
         sbox[x] = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
      end
      for (int x = 0; x < 256; x++) isbox[sbox[x]] = 8'(x);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) w[i][j] = 8'(4*i + j);
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
         if (i % 4 == 0) begin
            t = '{sbox[w[i-1][1]] ^ rcon, sbox[w[i-1][2]], sbox[w[i-1][3]], sbox[w[i-1][0]]};
            rcon = gmul(rcon, 8'h02);
         end
         for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
      end
      for (int r = 0; r < 11; r++)
         for (int i = 0; i < 16; i++) rk[r][8*i +: 8] = w[4*r + i/4][i%4];
   endtask

   function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input bit zk);
      logic [7:0]   m [4][4];
      logic [7:0]   t [4][4];
      logic [7:0]   imc [4];
      logic [7:0]   acc;
      logic [127:0] key, o;
      imc = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      key = zk ? '0 : rk[10];
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) m[r][c] = ct[8*(r+4*c) +: 8] ^ key[8*(r+4*c) +: 8];
      for (int rd = 9; rd >= 0; rd--) begin
         key = zk ? '0 : rk[rd];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][(c + r) % 4] = isbox[m[r][c]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r][c] ^= key[8*(r+4*c) +: 8];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               acc = 8'h00;
               for (int k = 0; k < 4; k++) acc ^= gmul(imc[(k - r + 4) % 4], t[k][c]);
               m[r][c] = (rd > 0) ? acc : t[r][c];
            end
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) o[8*(r+4*c) +: 8] = m[r][c];
      return o;
   endfunction

   // Issues start in cycle T (optionally held for hold cycles) and checks every cycle up to T+11.
   task automatic do_block(input logic [127:0] ct, input logic [127:0] exp_pt, input string tag,
                           input int hold, input bit chained);
      logic [127:0] k10;
      if (!chained) @(negedge clk);
      k10 = zero_keys ? '0 : rk[10];
      chk1({tag, "_ready_T"}, ready, 1'b1);
      chk({tag, "_rkidx_T"}, 128'(rk_idx), 128'(10));
      start = 1'b1;
      ciphertext_in = ct;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start = (k < hold);
         ciphertext_in = {$urandom, $urandom, $urandom, $urandom};
         chk({tag, "_rkidx"}, 128'(rk_idx), 128'(10 - k));
         chk1({tag, "_busy"}, busy, 1'b1);
         chk1({tag, "_ready_run"}, ready, 1'b0);
         chk1({tag, "_done_early"}, done, 1'b0);
         if (k == 1) chk({tag, "_initial_ark"}, plaintext_out, ct ^ k10);
      end
      @(negedge clk);
      start = 1'b0;
      chk1({tag, "_done"}, done, 1'b1);
      chk({tag, "_plaintext"}, plaintext_out, exp_pt);
      chk1({tag, "_ready_done"}, ready, 1'b1);
      chk({tag, "_rkidx_done"}, 128'(rk_idx), 128'(10));
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      ciphertext_in = '0;
`ifdef AES_INV_CIPHER_ABORT_EN
      abort = 1'b0;
`endif
      init_model();
      ct_ref = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      pt_ref = fips(128'h00112233445566778899aabbccddeeff);
      chk("model_rk10", rk[10], fips(128'h13111d7fe3944a17f307a78b4d2b30c5));
      chk("model_fips_pt", ref_decrypt(ct_ref, 1'b0), pt_ref);

      @(negedge clk);
      chk1("reset_ready", ready, 1'b1);
      chk1("reset_busy", busy, 1'b0);
      chk1("reset_done", done, 1'b0);
      chk("reset_rkidx", 128'(rk_idx), 128'(10));
      chk("reset_pt", plaintext_out, '0);
      rst = 1'b0;

      do_block(ct_ref, pt_ref, "basic", 1, 1'b0);
      @(negedge clk);
      chk1("basic_done_pulse", done, 1'b0);

      do_block(ct_ref, pt_ref, "b2b_first", 1, 1'b0);
      do_block(ct_ref, pt_ref, "b2b_second", 1, 1'b1);
      @(negedge clk);
      chk1("b2b_done_pulse", done, 1'b0);

      do_block(ct_ref, pt_ref, "start_busy", 6, 1'b0);
      @(negedge clk);
      chk1("start_busy_single_done", done, 1'b0);
      chk1("start_busy_not_requeued", busy, 1'b0);

      @(negedge clk);
      start = 1'b1;
      ciphertext_in = ct_ref;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         start = 1'b0;
      end
      #1 rst = 1'b1;
      #1;
      chk1("midrst_ready", ready, 1'b1);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_done", done, 1'b0);
      chk("midrst_rkidx", 128'(rk_idx), 128'(10));
      chk("midrst_pt", plaintext_out, '0);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk1("midrst_no_done", done, 1'b0);
      end
      do_block(ct_ref, pt_ref, "after_rst", 1, 1'b0);

      for (int n = 0; n < 4; n++) begin
         logic [127:0] ct;
         ct = {$urandom, $urandom, $urandom, $urandom};
         do_block(ct, ref_decrypt(ct, 1'b0), $sformatf("rand%0d", n), 1, 1'b0);
      end

      zero_keys = 1'b1;
      do_block(ct_ref, ref_decrypt(ct_ref, 1'b1), "wrongkey", 1, 1'b0);
      chk1("wrongkey_differs", plaintext_out != pt_ref, 1'b1);
      @(negedge clk);
      zero_keys = 1'b0;

`ifdef AES_INV_CIPHER_ABORT_EN
      @(negedge clk);
      start = 1'b1;
      ciphertext_in = ct_ref;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         start = 1'b0;
         abort = (k == 4);
      end
      @(negedge clk);
      abort = 1'b0;
      chk1("abort_ready", ready, 1'b1);
      chk("abort_pt", plaintext_out, '0);
      chk1("abort_done", done, 1'b0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk1("abort_no_done", done, 1'b0);
      end
      do_block(ct_ref, pt_ref, "after_abort", 1, 1'b0);
`endif

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_inv_cipher_iter.md
# aes_inv_cipher_iter

Iterative AES-128 inverse cipher datapath. It applies the FIPS-197 inverse cipher to one 128-bit block, one round per clock, and is the decrypt-side counterpart of the encrypt round logic. Round keys come from an external round-key store: the block drives an index and reads the key back combinationally in the same cycle. Key expansion is outside this block.

## Interface
Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is supported.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to decrypt ciphertext_in; sampled only while ready=1.
- ciphertext_in  input  128  input block; sampled in the start cycle only.
- ready  output  1  block is idle and will accept start.
- busy  output  1  round iteration in progress; always the inverse of ready.
- rk_idx  output  4  round-key index requested this cycle (0..10).
- rk_data  input  128  round key for rk_idx, valid in the same cycle.
- plaintext_out  output  128  result block; valid from the done cycle until the next accepted start.
- done  output  1  one-cycle pulse; plaintext_out is valid.

## Operation
- Byte packing:
  - State byte i occupies bits [8i+7:8i], for all 128-bit buses.
  - Byte i is FIPS byte i, at row i%4 and column i/4.
- State machine: IDLE and RUN; round counter rnd is 4 bits.
- IDLE:
  - ready=1 and rk_idx=10.
  - On start, the block loads state ← ciphertext_in ^ rk_data, sets rnd ← 9, and moves to RUN.
- RUN, with rk_idx=rnd:
  - For rnd 9..1: state ← InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data), then rnd ← rnd-1.
  - For rnd 0: state ← InvSubBytes(InvShiftRows(state)) ^ rk_data. The block sets done ← 1 and moves to IDLE.
- Datapath rules:
  - InvShiftRows rotates row r right by r columns.
  - InvSubBytes uses the 256-entry inverse S-box, 16 instances.
  - InvMixColumns multiplies by the matrix {0e,0b,0d,09} over GF(2^8), with reduction polynomial 0x11b.
- plaintext_out is the state register itself. There is no separate output register.
- A start asserted while busy=1 is ignored. It is not queued.
- rk_data is don't-care in any cycle where no state update occurs.

## Timing
- Reset values:
  - state=0, rnd=0, FSM in IDLE.
  - ready=1, busy=0, done=0, rk_idx=10.
  - plaintext_out=0.
- Latency:
  - start is high in cycle T.
  - The block is in RUN during cycles T+1..T+10.
  - done=1 in cycle T+11, with plaintext_out final.
- rk_idx sequence: cycle T shows 10, then T+1..T+10 show 9,8,…,0, then T+11 shows 10.
- ready returns to 1 in cycle T+11. A start in T+11 is accepted, giving a block throughput of one per 11 cycles.
- done is high for exactly one cycle. It is deasserted in every other cycle.
- Reset mid-RUN aborts the operation immediately: all outputs return to their reset values and no done is produced.

## Configuration
- Macro AES_INV_CIPHER_ABORT_EN.
- When defined:
  - An extra port abort (input, 1 bit) is present.
  - abort=1 in any RUN cycle clears state to 0 and sets rnd ← 0; the block returns to IDLE next cycle with no done.
  - abort is ignored in IDLE.
- When undefined, the abort port does not exist and RUN always completes.

## Test plan
All vectors use FIPS-197 Appendix C.1 with key 000102…0f. The bench round-key model stores the correct rk[0..10], with rk[10]=13111d7fe3944a17f307a78b4d2b30c5 in FIPS byte order.
- Basic decrypt: ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a with start pulsed in T → done only in T+11, plaintext 00112233445566778899aabbccddeeff, and rk_idx 10,9,…,0,10 over T..T+11.
- Back-to-back: a second start (same ciphertext) asserted in the done cycle → the second done lands exactly 11 cycles later with the same plaintext; plaintext_out holds the first result until the second start's edge.
- Start while busy: start held high T..T+5 with a different ciphertext in T+3 → only one done at T+11, with the result for the T ciphertext; ready=0 during T+1..T+10.
- Reset mid-op: rst asserted asynchronously in T+5 → outputs immediately at reset values; no done afterward; a fresh start then decrypts correctly.
- Wrong key: rk_data forced to all-zero keys → done still at T+11; plaintext_out ≠ 00112233…eeff, and matches a software model of the inverse cipher with zero keys.
- Abort (AES_INV_CIPHER_ABORT_EN only): abort=1 in T+4 → IDLE in T+5 with ready=1, plaintext_out=0, and no done.
